// File: rtl/pid_pwm_out_pkg.sv
// ============================================================================
// pid_pwm_out_pkg: shared encodings and the sign-magnitude helper for pid_pwm_out
// Rev 1.0
// ============================================================================
`default_nettype none

package pid_pwm_out_pkg;

   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DEAD = 1'b1
   } chan_state_t;

   // Absolute value of a sign-extended input, clamped to 2^pw-1 so the most
   // negative code cannot wrap back to a small duty.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] v,
                                           input int                 pw);
      logic [31:0] mag;
      logic [31:0] lim;
      mag = v[31] ? 32'(-v) : 32'(v);
      lim = (32'd1 << pw) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pid_pwm_chan.sv
// ============================================================================
// pid_pwm_chan: one channel's pending value, dead-time FSM, duty and PWM compare
// Rev 1.0
// ============================================================================
`default_nettype none

module pid_pwm_chan
   import pid_pwm_out_pkg::*;
#(
   parameter int ow   = 12,
   parameter int pwmw = ow - 1,
   parameter int dead = 2,
   parameter int dw   = 3
) (
   input  logic            clk_pid,
   input  logic            reset,
   input  logic            cap,
   input  logic [ow-1:0]   din,
   input  logic            wrap,
   input  logic [pwmw-1:0] cnt,
   output logic            pwm,
   output logic            dir
);

   localparam logic [dw-1:0] DEAD_LOAD = dw'((dead > 0) ? dead - 1 : 0);

   logic [ow-1:0]   pend;
   logic            pend_valid;
   logic [pwmw-1:0] duty;
   logic [pwmw-1:0] mag;
   logic [dw-1:0]   deadcnt;
   logic            sign;
   chan_state_t     state;

   assign sign = pend[ow-1];
   assign mag  = pwmw'(sat_abs(32'($signed(pend)), pwmw));

   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         pend       <= '0;
         pend_valid <= 1'b0;
         duty       <= '0;
         deadcnt    <= '0;
         dir        <= DIR_POS;
         pwm        <= 1'b0;
         state      <= ST_RUN;
      end else begin
         pwm <= (cnt < duty);

         if (wrap) begin
            case (state)
               ST_RUN: begin
                  if (pend_valid) begin
                     if (mag == '0) begin
                        duty       <= '0;
                        pend_valid <= 1'b0;
                     end else if (sign == dir) begin
                        duty       <= mag;
                        pend_valid <= 1'b0;
                     end else if (dead == 0) begin
                        dir        <= sign ? DIR_NEG : DIR_POS;
                        duty       <= mag;
                        pend_valid <= 1'b0;
                     end else begin
                        // Reversal: hold the bridge off; pend stays armed for the exit.
                        duty    <= '0;
                        deadcnt <= DEAD_LOAD;
                        state   <= ST_DEAD;
                     end
                  end
               end
               ST_DEAD: begin
                  if (deadcnt != '0) begin
                     deadcnt <= deadcnt - 1'b1;
                  end else begin
                     if (mag == '0) begin
                        duty <= '0;
                     end else begin
                        dir  <= sign ? DIR_NEG : DIR_POS;
                        duty <= mag;
                     end
                     pend_valid <= 1'b0;
                     state      <= ST_RUN;
                  end
               end
               default: state <= ST_RUN;
            endcase
         end

         // Placed after the wrap update so a same-cycle capture wins over the clear.
         if (cap) begin
            pend       <= din;
            pend_valid <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pid_pwm_out.sv
// ============================================================================
// pid_pwm_out: captures the multiplexed PID bus and drives per-channel PWM/dir
// Rev 1.0
// ============================================================================
`default_nettype none

module pid_pwm_out
   import pid_pwm_out_pkg::*;
#(
   parameter int aw   = 1,
   parameter int an   = 1 << aw,
   parameter int ow   = 12,
   parameter int pwmw = ow - 1,
   parameter int dead = 2,
   parameter int dw   = 3
) (
   input  logic          clk_pid,
   input  logic          reset,
   input  logic          ce,
   input  logic [aw-1:0] a,
   input  logic [ow-1:0] m_k_out,
   output logic [an-1:0] pwm,
   output logic [an-1:0] dir,
   output logic          period_end
);

   // Period is 2^pwmw-1 clocks so a full-scale duty keeps the output high.
   localparam logic [pwmw-1:0] MAXC = pwmw'((1 << pwmw) - 2);

   logic [pwmw-1:0] cnt;
   logic            ce_d;
   logic            capture_en;
   logic            wrap;
   logic [an-1:0]   cap;

   assign wrap       = (cnt == MAXC);
   assign capture_en = ce & ~ce_d;

   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         ce_d       <= 1'b0;
         period_end <= 1'b0;
      end else begin
         ce_d       <= ce;
         period_end <= wrap;
         cnt        <= wrap ? '0 : cnt + 1'b1;
      end
   end

   generate
      for (genvar i = 0; i < an; i++) begin : g_chan
         assign cap[i] = capture_en && (a == aw'(i));

         pid_pwm_chan #(
            .ow   (ow),
            .pwmw (pwmw),
            .dead (dead),
            .dw   (dw)
         ) u_chan (
            .clk_pid (clk_pid),
            .reset   (reset),
            .cap     (cap[i]),
            .din     (m_k_out),
            .wrap    (wrap),
            .cnt     (cnt),
            .pwm     (pwm[i]),
            .dir     (dir[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pid_pwm_out.sv
// ============================================================================
// tb_pid_pwm_out: directed stimulus with a per-period scoreboard for pid_pwm_out
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pid_pwm_out;

   localparam int PER = 2047;

   logic        clk_pid = 1'b0;
   logic        reset   = 1'b1;
   logic        ce      = 1'b0;
   logic [0:0]  a       = 1'b0;
   logic [11:0] m_k_out = '0;
   logic [1:0]  pwm;
   logic [1:0]  dir;
   logic        period_end;

   typedef struct {
      int   win;
      int   ch;
      int   high;
      logic d;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   sw      = 0;
   int   mon_win = 0;

   always #5 clk_pid = ~clk_pid;

   pid_pwm_out dut (
      .clk_pid    (clk_pid),
      .reset      (reset),
      .ce         (ce),
      .a          (a),
      .m_k_out    (m_k_out),
      .pwm        (pwm),
      .dir        (dir),
      .period_end (period_end)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_pid);
      #1;
   endtask

   task automatic expect_win(input int w, input int ch, input int high, input logic d);
      exp_t e;
      e.win  = w;
      e.ch   = ch;
      e.high = high;
      e.d    = d;
      sb.push_back(e);
   endtask

   task automatic wait_wrap();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!period_end && n < PER + 50);
      check("wrap_seen", int'(period_end), 1);
      sw++;
   endtask

   task automatic pulse(input logic [0:0] ch, input int val, input int hold);
      a       = ch;
      m_k_out = 12'(val);
      ce      = 1'b1;
      repeat (hold) tick();
      ce = 1'b0;
      tick();
   endtask

   // Monitor: accumulates pwm-high clocks per period window and scores them.
   int         acc0 = 0;
   int         acc1 = 0;
   int         len  = 0;
   logic [1:0] wdir = '0;
   bit         new_win = 1'b1;
   bit         partial = 1'b1;

   always @(negedge clk_pid) begin
      exp_t e;
      if (reset) begin
         acc0    = 0;
         acc1    = 0;
         len     = 0;
         new_win = 1'b1;
         partial = 1'b1;
      end else begin
         if (new_win) begin
            wdir    = dir;
            new_win = 1'b0;
         end
         acc0 += int'(pwm[0]);
         acc1 += int'(pwm[1]);
         len++;
         if (period_end) begin
            if (!partial)
               check($sformatf("win%0d_len", mon_win), len, PER);
            while (sb.size() > 0 && sb[0].win <= mon_win) begin
               e = sb.pop_front();
               if (e.win < mon_win) begin
                  check($sformatf("win%0d_ch%0d_missed", e.win, e.ch), 0, 1);
               end else begin
                  check($sformatf("win%0d_ch%0d_high", e.win, e.ch),
                        (e.ch == 0) ? acc0 : acc1, e.high);
                  check($sformatf("win%0d_ch%0d_dir", e.win, e.ch),
                        int'(wdir[e.ch]), int'(e.d));
               end
            end
            mon_win++;
            acc0    = 0;
            acc1    = 0;
            len     = 0;
            new_win = 1'b1;
            partial = 1'b0;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi;

      repeat (3) tick();
      check("rst_pwm", int'(pwm), 0);
      check("rst_dir", int'(dir), 0);
      check("rst_period_end", int'(period_end), 0);
      check("rst_cnt", int'(dut.cnt), 0);
      reset = 1'b0;
      sw    = 0;

      // +512 on ch0, visible from window 1
      pulse(1'b0, 512, 3);
      expect_win(1, 0, 512, 1'b0);
      expect_win(1, 1, 0, 1'b0);
      expect_win(2, 0, 512, 1'b0);
      wait_wrap();
      wait_wrap();

      // -2048 on ch0: two dead periods, then full scale negative
      pulse(1'b0, -2048, 3);
      expect_win(3, 0, 0, 1'b0);
      expect_win(4, 0, 0, 1'b0);
      expect_win(5, 0, 2047, 1'b1);
      repeat (3) wait_wrap();

      // long ce pulse on ch1: only the value at the rising edge counts
      a       = 1'b1;
      m_k_out = 12'd100;
      ce      = 1'b1;
      repeat (50) tick();
      m_k_out = 12'd900;
      repeat (50) tick();
      ce = 1'b0;
      tick();
      expect_win(6, 1, 100, 1'b0);
      expect_win(6, 0, 2047, 1'b1);
      wait_wrap();
      pulse(1'b1, 900, 3);
      expect_win(7, 1, 900, 1'b0);
      wait_wrap();

      // capture on ch1 exactly in the wrap cycle
      repeat (PER - 1) tick();
      a       = 1'b1;
      m_k_out = 12'd300;
      ce      = 1'b1;
      tick();
      check("wrap_align", int'(period_end), 1);
      sw++;
      ce = 1'b0;
      expect_win(8, 1, 900, 1'b0);
      expect_win(8, 0, 2047, 1'b1);
      expect_win(9, 1, 300, 1'b0);
      expect_win(9, 0, 2047, 1'b1);
      wait_wrap();

      // zero while negative: no dead time, dir held; then -50
      pulse(1'b0, 0, 3);
      expect_win(10, 0, 0, 1'b1);
      wait_wrap();
      pulse(1'b0, -50, 3);
      expect_win(11, 0, 50, 1'b1);
      wait_wrap();

      // enter DEAD, then reset with ce high
      pulse(1'b0, 700, 3);
      wait_wrap();
      hi = 0;
      repeat (100) begin
         tick();
         hi += int'(pwm[0]);
      end
      check("dead_pwm_low", hi, 0);
      check("dead_dir_held", int'(dir[0]), 1);
      a       = 1'b0;
      m_k_out = 12'd700;
      ce      = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_pwm", int'(pwm), 0);
      check("mid_rst_dir", int'(dir), 0);
      check("mid_rst_cnt", int'(dut.cnt), 0);
      check("mid_rst_period_end", int'(period_end), 0);
      repeat (3) tick();
      reset = 1'b0;
      expect_win(12, 0, 0, 1'b0);
      expect_win(12, 1, 0, 1'b0);
      expect_win(13, 0, 700, 1'b0);
      expect_win(13, 1, 0, 1'b0);
      n = 0;
      do begin
         tick();
         n++;
      end while (!period_end && n < PER + 50);
      check("first_wrap_after_reset", n, PER);
      sw++;
      ce = 1'b0;
      wait_wrap();
      repeat (10) tick();
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
